// File: rtl/nco_pkg.sv
// nco_pkg: shared definitions for the NCO SPI command path.
//   - Command byte field positions and type encodings.
//   - Decoder FSM state encoding.
//   - cmd_legal(): checks reserved bits and the NCO index range of a command byte.
package nco_pkg;

  localparam int CMD_TYPE_BIT = 7;
  localparam int CMD_RSVD_MSB = 6;
  localparam int CMD_RSVD_LSB = 3;
  localparam int CMD_IDX_MSB  = 2;
  localparam int CMD_IDX_LSB  = 0;

  localparam logic CMD_TUNING = 1'b0;
  localparam logic CMD_MUX    = 1'b1;

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_DATA    = 2'd1,
    ST_DISCARD = 2'd2
  } dec_state_t;

  // A command is legal when its reserved field is clear and, for tuning
  // writes, the index addresses an existing NCO. Mux writes ignore the index.
  function automatic logic cmd_legal(input logic [7:0] cmd, input int num_nco);
    logic [3:0] idx_ext;
    idx_ext = {1'b0, cmd[CMD_IDX_MSB:CMD_IDX_LSB]};
    return (cmd[CMD_RSVD_MSB:CMD_RSVD_LSB] == 4'd0) &&
           ((cmd[CMD_TYPE_BIT] == CMD_MUX) || (int'(idx_ext) < num_nco));
  endfunction

endpackage

// File: rtl/nco_frame_timeout.sv
// nco_frame_timeout: idle-cycle counter for SPI command frames.
//   i_clock, i_reset_n : clock, asynchronous active-low reset
//   i_enable           : count idle cycles while a frame is in progress
//   i_clear            : restart the count (byte received, or no frame open)
//   i_limit            : number of idle cycles allowed; 0 disables expiry
//   o_expire           : high in the idle cycle that reaches i_limit
module nco_frame_timeout
  import nco_pkg::*;
#(
  parameter int CNT_W = 16
) (
  input  logic             i_clock,
  input  logic             i_reset_n,
  input  logic             i_enable,
  input  logic             i_clear,
  input  logic [CNT_W-1:0] i_limit,
  output logic             o_expire
);

  logic [CNT_W-1:0] count_r;

  // Idle counter: cleared on activity, advances once per idle cycle.
  always_ff @(posedge i_clock or negedge i_reset_n) begin
    if (!i_reset_n) begin
      count_r <= '0;
    end else if (i_clear || !i_enable || (i_limit == '0)) begin
      count_r <= '0;
    end else begin
      count_r <= count_r + CNT_W'(1);
    end
  end

  // Expiry is flagged during the idle cycle that completes the allowance, so
  // the owner aborts on the edge ending exactly i_limit idle cycles.
  always_comb begin
    if (i_enable && !i_clear && (i_limit != '0)) begin
      o_expire = (count_r == (i_limit - CNT_W'(1)));
    end else begin
      o_expire = 1'b0;
    end
  end

endmodule

// File: rtl/nco_command_decoder.sv
// nco_command_decoder: turns SPI bytes into NCO tuning / mux register writes.
//   i_clock, i_reset_n : system clock, asynchronous active-low reset
//   i_cs_active        : synchronised chip-select-active flag
//   i_byte_valid       : one-cycle strobe, i_byte_data holds a byte
//   i_byte_data        : received byte
//   o_tuning_words     : register bank, NCO k at [k*WORD_W +: WORD_W]
//   o_update           : one-cycle pulse on bit k when NCO k's word changes
//   o_mux_control      : output mux control register
//   o_frame_error      : one-cycle pulse on a rejected or aborted frame
//   o_busy             : a frame is partially received
module nco_command_decoder
  import nco_pkg::*;
#(
  parameter int NUM_NCO        = 8,
  parameter int WORD_W         = 24,
  parameter int MUX_W          = 8,
  parameter int TIMEOUT_CYCLES = 65535
) (
  input  logic                      i_clock,
  input  logic                      i_reset_n,
  input  logic                      i_cs_active,
  input  logic                      i_byte_valid,
  input  logic [7:0]                i_byte_data,
  output logic [NUM_NCO*WORD_W-1:0] o_tuning_words,
  output logic [NUM_NCO-1:0]        o_update,
  output logic [MUX_W-1:0]          o_mux_control,
  output logic                      o_frame_error,
  output logic                      o_busy
);

  localparam int TO_W = (TIMEOUT_CYCLES > 0) ? $clog2(TIMEOUT_CYCLES + 1) : 1;

  dec_state_t        state_r;
  logic              type_r;
  logic [2:0]        idx_r;
  logic [2:0]        remaining_r;
  logic [WORD_W-1:0] shadow_r;
  logic [WORD_W-1:0] shadow_next_s;
  logic [WORD_W-1:0] tuning_r [NUM_NCO];
  logic [MUX_W-1:0]  mux_r;
  logic [NUM_NCO-1:0] update_r;
  logic              frame_error_r;
  logic              busy_r;
  logic              in_data_s;
  logic              timeout_clear_s;
  logic              timeout_expire_s;

  assign in_data_s       = (state_r == ST_DATA);
  assign timeout_clear_s = !in_data_s || i_byte_valid;

  nco_frame_timeout #(
    .CNT_W (TO_W)
  ) u_timeout (
    .i_clock   (i_clock),
    .i_reset_n (i_reset_n),
    .i_enable  (in_data_s),
    .i_clear   (timeout_clear_s),
    .i_limit   (TO_W'(TIMEOUT_CYCLES)),
    .o_expire  (timeout_expire_s)
  );

  // MSB-first assembly; for 8-bit words the shift leaves only the new byte.
  always_comb begin
    shadow_next_s = (shadow_r << 8) | WORD_W'(i_byte_data);
  end

  // Frame decoder FSM together with the register bank it writes.
  always_ff @(posedge i_clock or negedge i_reset_n) begin
    if (!i_reset_n) begin
      state_r       <= ST_IDLE;
      type_r        <= CMD_TUNING;
      idx_r         <= 3'd0;
      remaining_r   <= 3'd0;
      shadow_r      <= '0;
      mux_r         <= '0;
      update_r      <= '0;
      frame_error_r <= 1'b0;
      busy_r        <= 1'b0;
      for (int k = 0; k < NUM_NCO; k++) begin
        tuning_r[k] <= '0;
      end
    end else begin
      update_r      <= '0;
      frame_error_r <= 1'b0;
      case (state_r)
        ST_IDLE: begin
          if (i_byte_valid && i_cs_active) begin
            busy_r <= 1'b1;
            if (cmd_legal(i_byte_data, NUM_NCO)) begin
              state_r     <= ST_DATA;
              type_r      <= i_byte_data[CMD_TYPE_BIT];
              idx_r       <= i_byte_data[CMD_IDX_MSB:CMD_IDX_LSB];
              remaining_r <= (i_byte_data[CMD_TYPE_BIT] == CMD_MUX) ? 3'd1 : 3'(WORD_W / 8);
              shadow_r    <= '0;
            end else begin
              frame_error_r <= 1'b1;
              state_r       <= ST_DISCARD;
            end
          end
        end
        ST_DATA: begin
          // Chip-select drop outranks a byte in the same cycle.
          if (!i_cs_active) begin
            frame_error_r <= 1'b1;
            busy_r        <= 1'b0;
            state_r       <= ST_IDLE;
          end else if (i_byte_valid) begin
            shadow_r    <= shadow_next_s;
            remaining_r <= remaining_r - 3'd1;
            if (remaining_r == 3'd1) begin
              state_r <= ST_IDLE;
              busy_r  <= 1'b0;
              if (type_r == CMD_MUX) begin
                mux_r <= i_byte_data[MUX_W-1:0];
              end else begin
                for (int k = 0; k < NUM_NCO; k++) begin
                  if (idx_r == 3'(k)) begin
                    tuning_r[k] <= shadow_next_s;
                    update_r[k] <= 1'b1;
                  end
                end
              end
            end
          end else if (timeout_expire_s) begin
            frame_error_r <= 1'b1;
            busy_r        <= 1'b0;
            state_r       <= ST_IDLE;
          end
        end
        ST_DISCARD: begin
          if (!i_cs_active) begin
            busy_r  <= 1'b0;
            state_r <= ST_IDLE;
          end
        end
        default: begin
          busy_r  <= 1'b0;
          state_r <= ST_IDLE;
        end
      endcase
    end
  end

  for (genvar g = 0; g < NUM_NCO; g++) begin : g_flat
    assign o_tuning_words[g*WORD_W +: WORD_W] = tuning_r[g];
  end

  assign o_update      = update_r;
  assign o_mux_control = mux_r;
  assign o_frame_error = frame_error_r;
  assign o_busy        = busy_r;

endmodule

// File: tb/tb_nco_command_decoder.sv
module tb_nco_command_decoder;

  localparam int NUM_NCO        = 8;
  localparam int WORD_W         = 24;
  localparam int MUX_W          = 8;
  localparam int TIMEOUT_CYCLES = 16;

  logic                      i_clock = 1'b0;
  logic                      i_reset_n;
  logic                      i_cs_active;
  logic                      i_byte_valid;
  logic [7:0]                i_byte_data;
  logic [NUM_NCO*WORD_W-1:0] o_tuning_words;
  logic [NUM_NCO-1:0]        o_update;
  logic [MUX_W-1:0]          o_mux_control;
  logic                      o_frame_error;
  logic                      o_busy;

  nco_command_decoder #(
    .NUM_NCO        (NUM_NCO),
    .WORD_W         (WORD_W),
    .MUX_W          (MUX_W),
    .TIMEOUT_CYCLES (TIMEOUT_CYCLES)
  ) dut (
    .i_clock        (i_clock),
    .i_reset_n      (i_reset_n),
    .i_cs_active    (i_cs_active),
    .i_byte_valid   (i_byte_valid),
    .i_byte_data    (i_byte_data),
    .o_tuning_words (o_tuning_words),
    .o_update       (o_update),
    .o_mux_control  (o_mux_control),
    .o_frame_error  (o_frame_error),
    .o_busy         (o_busy)
  );

  always #5 i_clock = ~i_clock;

  int total = 0;
  int bad   = 0;

  // Reference state: what the registers should hold.
  logic [WORD_W-1:0] m_tune [NUM_NCO];
  logic [MUX_W-1:0]  m_mux;

  // Pulse counters observed on the falling edge.
  int err_cnt = 0;
  int upd_cnt [NUM_NCO];
  int snap_err;
  int snap_upd [NUM_NCO];

  always @(negedge i_clock) begin
    if (o_frame_error) err_cnt++;
    for (int k = 0; k < NUM_NCO; k++) begin
      if (o_update[k]) upd_cnt[k]++;
    end
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expd);
    total++;
    assert (obs === expd) else begin
      bad++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, expd);
    end
  endtask

  task automatic tick();
    @(posedge i_clock);
    #1;
  endtask

  task automatic send_byte(input logic [7:0] b);
    i_byte_valid = 1'b1;
    i_byte_data  = b;
    tick();
    i_byte_valid = 1'b0;
  endtask

  task automatic take_snap();
    snap_err = err_cnt;
    for (int k = 0; k < NUM_NCO; k++) snap_upd[k] = upd_cnt[k];
  endtask

  // Parse the bytes sent under one chip-select assertion as a list of frames.
  task automatic model_apply(input logic [7:0] q[$], output int nerr, output int nupd [NUM_NCO]);
    int pos;
    int n;
    logic [7:0] c;
    nerr = 0;
    for (int k = 0; k < NUM_NCO; k++) nupd[k] = 0;
    pos = 0;
    while (pos < q.size()) begin
      c = q[pos];
      pos++;
      if ((c[6:3] != 4'd0) || (!c[7] && (int'(c[2:0]) >= NUM_NCO))) begin
        nerr++;
        break;
      end
      n = c[7] ? 1 : WORD_W / 8;
      if (q.size() - pos < n) begin
        nerr++;
        break;
      end
      if (c[7]) begin
        m_mux = q[pos][MUX_W-1:0];
      end else begin
        m_tune[c[2:0]] = {q[pos], q[pos+1], q[pos+2]};
        nupd[c[2:0]]++;
      end
      pos += n;
    end
  endtask

  task automatic check_all(input string tag, input int nerr, input int nupd [NUM_NCO]);
    for (int k = 0; k < NUM_NCO; k++)
      chk($sformatf("%s slice%0d", tag, k), 32'(o_tuning_words[k*WORD_W +: WORD_W]), 32'(m_tune[k]));
    chk($sformatf("%s mux", tag), 32'(o_mux_control), 32'(m_mux));
    chk($sformatf("%s errors", tag), 32'(err_cnt - snap_err), 32'(nerr));
    for (int k = 0; k < NUM_NCO; k++)
      chk($sformatf("%s updates%0d", tag, k), 32'(upd_cnt[k] - snap_upd[k]), 32'(nupd[k]));
    chk($sformatf("%s busy", tag), 32'(o_busy), 32'd0);
  endtask

  // One chip-select assertion carrying the given bytes, then model check.
  task automatic frame_test(input string tag, input logic [7:0] q[$], input bit gaps, input bit byte_on_drop);
    int nerr;
    int nupd [NUM_NCO];
    take_snap();
    i_cs_active = 1'b1;
    tick();
    foreach (q[i]) begin
      send_byte(q[i]);
      if (gaps) repeat ($urandom_range(3, 0)) tick();
    end
    i_cs_active = 1'b0;
    if (byte_on_drop) begin
      i_byte_valid = 1'b1;
      i_byte_data  = 8'($urandom);
    end
    tick();
    i_byte_valid = 1'b0;
    tick();
    tick();
    model_apply(q, nerr, nupd);
    check_all(tag, nerr, nupd);
  endtask

  task automatic gen_rand(output logic [7:0] q[$]);
    int nf;
    int kind;
    logic [7:0] c;
    q.delete();
    nf = $urandom_range(3, 1);
    for (int f = 0; f < nf; f++) begin
      kind = $urandom_range(9, 0);
      if (kind <= 5) begin
        c = {5'b00000, 3'($urandom_range(7, 0))};
        q.push_back(c);
        repeat (3) q.push_back(8'($urandom));
      end else if (kind <= 7) begin
        c = {5'b10000, 3'($urandom_range(7, 0))};
        q.push_back(c);
        q.push_back(8'($urandom));
      end else if (kind == 8) begin
        c = 8'($urandom);
        c[6:3] = 4'($urandom_range(15, 1));
        q.push_back(c);
        repeat (2) q.push_back(8'($urandom));
      end else begin
        c = {5'b00000, 3'($urandom_range(7, 0))};
        q.push_back(c);
        repeat ($urandom_range(2, 0)) q.push_back(8'($urandom));
        break;
      end
    end
  endtask

  initial begin
    logic [7:0] q[$];
    int nerr;
    int nupd [NUM_NCO];
    int seen;

    for (int k = 0; k < NUM_NCO; k++) begin
      m_tune[k]  = '0;
      upd_cnt[k] = 0;
    end
    m_mux        = '0;
    i_reset_n    = 1'b0;
    i_cs_active  = 1'b0;
    i_byte_valid = 1'b0;
    i_byte_data  = 8'h00;

    // Reset state
    #12;
    chk("reset words", 32'(o_tuning_words != '0), 32'd0);
    chk("reset mux", 32'(o_mux_control), 32'd0);
    chk("reset update", 32'(o_update), 32'd0);
    chk("reset error", 32'(o_frame_error), 32'd0);
    chk("reset busy", 32'(o_busy), 32'd0);
    i_reset_n = 1'b1;
    tick();
    tick();

    // Tuning write to NCO 3 with latency check
    take_snap();
    q = {8'h03, 8'h12, 8'h34, 8'h56};
    i_cs_active = 1'b1;
    tick();
    foreach (q[i]) send_byte(q[i]);
    @(negedge i_clock);
    chk("t1 slice3 latency", 32'(o_tuning_words[3*WORD_W +: WORD_W]), 32'h123456);
    chk("t1 update pulse", 32'(o_update), 32'h08);
    @(negedge i_clock);
    chk("t1 update cleared", 32'(o_update), 32'h00);
    i_cs_active = 1'b0;
    tick();
    tick();
    model_apply(q, nerr, nupd);
    check_all("t1", nerr, nupd);

    // Mux write
    frame_test("mux", {8'h80, 8'hA5}, 1'b0, 1'b0);

    // Abort by chip-select drop (slice 1 preloaded first)
    frame_test("pre1", {8'h01, 8'h11, 8'h22, 8'h33}, 1'b0, 1'b0);
    frame_test("abort", {8'h01, 8'hFF}, 1'b0, 1'b0);

    // Illegal command, then a good frame
    frame_test("illegal", {8'h48, 8'h11, 8'h22, 8'h33}, 1'b0, 1'b0);
    frame_test("after_ill", {8'h00, 8'hAA, 8'hBB, 8'hCC}, 1'b0, 1'b0);

    // Back-to-back frames in one chip select, byte dropped with CS
    frame_test("b2b", {8'h07, 8'h01, 8'h02, 8'h03, 8'h80, 8'h3C}, 1'b0, 1'b1);

    // Timeout after 16 idle cycles, next byte is a command
    take_snap();
    i_cs_active = 1'b1;
    tick();
    send_byte(8'h02);
    send_byte(8'h01);
    seen = 0;
    repeat (TIMEOUT_CYCLES) begin
      @(negedge i_clock);
      if (o_frame_error) seen++;
    end
    chk("to no early error", 32'(seen), 32'd0);
    @(negedge i_clock);
    chk("to error pulse", 32'(o_frame_error), 32'd1);
    chk("to busy low", 32'(o_busy), 32'd0);
    send_byte(8'h02);
    chk("to next cmd busy", 32'(o_busy), 32'd1);
    send_byte(8'h00);
    send_byte(8'h00);
    send_byte(8'h05);
    i_cs_active = 1'b0;
    tick();
    tick();
    q = {8'h02, 8'h00, 8'h00, 8'h05};
    model_apply(q, nerr, nupd);
    nerr = nerr + 1;
    check_all("timeout", nerr, nupd);

    // Randomized frames
    for (int t = 0; t < 25; t++) begin
      gen_rand(q);
      frame_test($sformatf("rand%0d", t), q, 1'b1, 1'($urandom_range(1, 0)));
    end

    // Reset in the middle of a frame
    frame_test("pre4", {8'h04, 8'h01, 8'h02, 8'h03}, 1'b0, 1'b0);
    i_cs_active = 1'b1;
    tick();
    send_byte(8'h04);
    send_byte(8'h11);
    #2;
    i_reset_n = 1'b0;
    #1;
    chk("mid rst words", 32'(o_tuning_words != '0), 32'd0);
    chk("mid rst mux", 32'(o_mux_control), 32'd0);
    chk("mid rst update", 32'(o_update), 32'd0);
    chk("mid rst error", 32'(o_frame_error), 32'd0);
    chk("mid rst busy", 32'(o_busy), 32'd0);
    for (int k = 0; k < NUM_NCO; k++) m_tune[k] = '0;
    m_mux = '0;
    i_cs_active = 1'b0;
    tick();
    #3;
    i_reset_n = 1'b1;
    tick();
    frame_test("post_rst", {8'h04, 8'hDE, 8'hAD, 8'hBE}, 1'b1, 1'b0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/nco_command_decoder.md
Name: nco_command_decoder

Overview:
- Sits directly downstream of the NCO SPI interface: consumes received bytes (byte-valid strobe plus data) and the synchronised chip-select-active flag.
- Assembles bytes into command frames and writes phase-increment (tuning) words into a bank of per-NCO registers, or writes the output mux control register.
- Registers hold their values between frames; NCO cores read them continuously.
- Single clock domain (the FPGA system clock); all inputs are already synchronous.

Parameters:
- NUM_NCO, 8, number of NCO tuning registers (1..8); index field is 3 bits.
- WORD_W, 24, tuning word width; must be a multiple of 8 (8..32).
- MUX_W, 8, width of the mux control register (1..8).
- TIMEOUT_CYCLES, 65535, idle clocks allowed between bytes inside a frame before abort; 0 disables the timeout.

Ports:
- i_clock  in  1  system clock.
- i_reset_n  in  1  asynchronous, active-low reset.
- i_cs_active  in  1  high while SPI chip select is asserted (synchronised).
- i_byte_valid  in  1  one-cycle strobe: i_byte_data holds a complete byte.
- i_byte_data  in  8  received byte, MSB first as shifted.
- o_tuning_words  out  NUM_NCO*WORD_W  flattened register bank; NCO k occupies bits [k*WORD_W +: WORD_W].
- o_update  out  NUM_NCO  one-cycle pulse on bit k in the cycle NCO k's word changes.
- o_mux_control  out  MUX_W  mux control register.
- o_frame_error  out  1  one-cycle pulse on any rejected or aborted frame.
- o_busy  out  1  high while a frame is partially received.

Behaviour:
- Reset: all tuning words 0, o_mux_control 0, o_update 0, o_frame_error 0, o_busy 0, FSM in IDLE, byte counter 0, timeout counter 0.
- Command byte fields:
  - bit7 = type: 0 = tuning write, 1 = mux write.
  - bits[6:3] reserved, must be 0.
  - bits[2:0] = NCO index (ignored for mux writes).
- Frame format:
  - Tuning frame: command byte, then WORD_W/8 data bytes, MSB first.
  - Mux frame: command byte, then 1 data byte; the low MUX_W bits are used.
- FSM state IDLE:
  - A valid byte with i_cs_active high is decoded as a command.
  - A legal command goes to DATA: latch type and index, load the remaining-byte count, clear the shadow register.
  - Reserved bits nonzero, or index >= NUM_NCO on a tuning write: pulse o_frame_error and go to DISCARD.
- FSM state DATA:
  - Each valid byte shifts into the WORD_W shadow (shadow <= {shadow, byte}) and decrements the count.
  - On the final byte, commit in the next clock edge's result: the target register takes the assembled value, o_update[k] pulses in that same cycle (mux writes pulse no o_update bit), and the FSM returns to IDLE.
  - Latency: the register is visible one cycle after the final i_byte_valid.
- FSM state DISCARD:
  - Ignore all bytes.
  - Return to IDLE when i_cs_active is low; no further error pulses.
- o_busy is high in DATA and DISCARD.
- Chip-select drop:
  - i_cs_active low in DATA: abort, pulse o_frame_error, go to IDLE, no register changed.
  - i_cs_active low in IDLE: no effect.
  - i_byte_valid and i_cs_active low in the same cycle: CS wins; the byte is dropped.
- Back-to-back frames under one CS assertion are legal; a byte arriving in the commit cycle is decoded as the next command.
- Timeout (DATA only):
  - The counter resets on each valid byte and increments otherwise.
  - Reaching TIMEOUT_CYCLES: abort exactly as for a CS drop.
- Asynchronous reset mid-frame discards the shadow and clears all registers immediately.

Decomposition:
- Shared package nco_pkg:
  - command bit positions (CMD_TYPE_BIT=7, CMD_RSVD_MSB/LSB=6/3, CMD_IDX_MSB/LSB=2/0);
  - type encodings CMD_TUNING=0, CMD_MUX=1;
  - FSM state encoding (IDLE, DATA, DISCARD).
- One sub-module, nco_frame_timeout: loadable idle counter with clear and expire output, reusable by other SPI command blocks.
- The register bank stays inline.

Test Plan:
- Tuning write, NCO 3: CS high, bytes 0x03,0x12,0x34,0x56 -> slice 3 = 0x123456 one cycle after the last strobe; o_update = 8'b0000_1000 for one cycle; other slices unchanged.
- Mux write: bytes 0x80,0xA5 -> o_mux_control = 0xA5; o_update stays 0; no error.
- Abort: bytes 0x01,0xFF, then CS low -> o_frame_error pulses once; slice 1 stays at its previous value; o_busy falls.
- Illegal command: 0x48 (reserved bit set), then 0x11,0x22,0x33 -> one error pulse; no register change; next CS assertion with 0x00,0xAA,0xBB,0xCC writes slice 0 = 0xAABBCC.
- Back-to-back and timeout: tuning frame to NCO 7 immediately followed by a mux frame in one CS -> both commit. Separately, with TIMEOUT_CYCLES=16, send 0x02,0x01 then idle 16 clocks -> error pulse; the next byte 0x02 is treated as a command.
- Reset mid-frame: assert i_reset_n low after 2 bytes -> all outputs 0 asynchronously; after release, a full frame works normally.
